// File: rtl/div_pkg.sv
// Shared types and constants for the 16-bit divider request front-end.
package div_pkg;

  localparam int DIV_W = 16;
  localparam logic [DIV_W-1:0] DIV_ZERO_Q = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    HOLD
  } div_state_e;

endpackage

// File: rtl/div_req_fifo.sv
// Request FIFO: wrapping read/write pointers plus an occupancy count.
module div_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 36
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == FULL_LEVEL);
  assign empty   = (count == '0);
  assign level   = count;
  assign head    = mem[rptr];
  // Full blocks a push even when a pop happens on the same edge.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/div_16bit_issue.sv
// Issues buffered tagged requests one at a time to the sequential divider.
// Optional DIV_ZERO_BYPASS_EN answers zero-divisor requests without the divider.
module div_16bit_issue
  import div_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DIV_W-1:0]       in_a,
  input  logic [DIV_W-1:0]       in_b,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DIV_W-1:0]       out_q,
  output logic [DIV_W-1:0]       out_r,
  output logic [TAG_W-1:0]       out_tag,
  output logic                   out_dz,
  output logic                   div_start,
  output logic [DIV_W-1:0]       div_a,
  output logic [DIV_W-1:0]       div_b,
  input  logic [DIV_W-1:0]       div_result,
  input  logic [DIV_W-1:0]       div_remainder,
  input  logic                   div_done,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PW = TAG_W + 2 * DIV_W;

  div_state_e       state;
  logic [PW-1:0]    head;
  logic [DIV_W-1:0] head_a;
  logic [DIV_W-1:0] head_b;
  logic [TAG_W-1:0] head_tag;
  logic [TAG_W-1:0] tag_q;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             bypass;
  logic             first_wait;

  assign {head_tag, head_a, head_b} = head;
  assign in_ready = !fifo_full;
  assign pop      = (state == IDLE) && !fifo_empty;
  assign busy     = (state != IDLE);

  div_req_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(PW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (in_valid && in_ready),
    .push_data ({in_tag, in_a, in_b}),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

`ifdef DIV_ZERO_BYPASS_EN
  logic dz_q;
  assign bypass = (head_b == '0);
  assign out_dz = dz_q;
`else
  assign bypass = 1'b0;
  assign out_dz = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      div_start  <= 1'b0;
      div_a      <= '0;
      div_b      <= '0;
      tag_q      <= '0;
      out_q      <= '0;
      out_r      <= '0;
      out_tag    <= '0;
      out_valid  <= 1'b0;
      first_wait <= 1'b0;
`ifdef DIV_ZERO_BYPASS_EN
      dz_q       <= 1'b0;
`endif
    end else begin
      div_start <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            if (bypass) begin
              out_q     <= DIV_ZERO_Q;
              out_r     <= head_a;
              out_tag   <= head_tag;
              out_valid <= 1'b1;
              state     <= HOLD;
`ifdef DIV_ZERO_BYPASS_EN
              dz_q      <= 1'b1;
`endif
            end else begin
              div_a     <= head_a;
              div_b     <= head_b;
              tag_q     <= head_tag;
              div_start <= 1'b1;
              state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          first_wait <= 1'b1;
          state      <= WAIT;
        end
        WAIT: begin
          // div_done in the first WAIT cycle may belong to the previous operation.
          if (first_wait) begin
            first_wait <= 1'b0;
          end else if (div_done) begin
            out_q     <= div_result;
            out_r     <= div_remainder;
            out_tag   <= tag_q;
            out_valid <= 1'b1;
            state     <= HOLD;
`ifdef DIV_ZERO_BYPASS_EN
            dz_q      <= 1'b0;
`endif
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_16bit_issue.sv
// Self-checking bench for div_16bit_issue with a behavioural divider model and scoreboard.
module tb_div_16bit_issue;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [15:0]       in_a = '0;
  logic [15:0]       in_b = '0;
  logic [TAG_W-1:0]  in_tag = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [15:0]       out_q;
  logic [15:0]       out_r;
  logic [TAG_W-1:0]  out_tag;
  logic              out_dz;
  logic              div_start;
  logic [15:0]       div_a;
  logic [15:0]       div_b;
  logic [15:0]       div_result;
  logic [15:0]       div_remainder;
  logic              div_done;
  logic              busy;
  logic [2:0]        level;

  always #5 clk = ~clk;

  div_16bit_issue #(
    .DEPTH(DEPTH),
    .TAG_W(TAG_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_a          (in_a),
    .in_b          (in_b),
    .in_tag        (in_tag),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_q         (out_q),
    .out_r         (out_r),
    .out_tag       (out_tag),
    .out_dz        (out_dz),
    .div_start     (div_start),
    .div_a         (div_a),
    .div_b         (div_b),
    .div_result    (div_result),
    .div_remainder (div_remainder),
    .div_done      (div_done),
    .busy          (busy),
    .level         (level)
  );

  // Divider model: done rises lat edges after start is accepted and stays high
  // until the next start; with stale set it lingers one extra cycle.
  int          lat = 4;
  logic        stale = 1'b0;
  logic [15:0] m_a, m_b, m_q, m_r;
  logic        m_done, m_drop, m_pend;
  int          m_cnt;

  assign div_result    = m_q;
  assign div_remainder = m_r;
  assign div_done      = m_done;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_done <= 1'b0; m_drop <= 1'b0; m_pend <= 1'b0; m_cnt <= 0;
      m_q <= '0; m_r <= '0; m_a <= '0; m_b <= '0;
    end else if (div_start) begin
      m_a <= div_a; m_b <= div_b; m_cnt <= lat; m_pend <= 1'b1;
      if (stale) m_drop <= 1'b1;
      else m_done <= 1'b0;
    end else begin
      if (m_drop) begin m_done <= 1'b0; m_drop <= 1'b0; end
      if (m_cnt == 1) begin
        m_done <= 1'b1;
        m_pend <= 1'b0;
        m_q <= (m_b == 0) ? 16'hFFFF : m_a / m_b;
        m_r <= (m_b == 0) ? m_a : m_a % m_b;
      end
      if (m_cnt != 0) m_cnt <= m_cnt - 1;
    end
  end

  typedef struct packed {
    logic [15:0]      q;
    logic [15:0]      r;
    logic [TAG_W-1:0] tag;
    logic             dz;
  } res_t;

  typedef struct {
    logic [15:0]      a;
    logic [15:0]      b;
    logic [TAG_W-1:0] tag;
    logic [15:0]      q;
    logic [15:0]      r;
  } vec_t;

  res_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   starts = 0;
  int   n_out = 0;
  logic prev_start = 1'b0;
  logic in_xfer = 1'b0;
  logic rnd_ready = 1'b0;

  function automatic res_t ref_div(input logic [15:0] a, input logic [15:0] b,
                                   input logic [TAG_W-1:0] tag);
    res_t e;
    e.tag = tag;
    e.dz  = 1'b0;
    if (b == 0) begin
      e.q = 16'hFFFF;
      e.r = a;
`ifdef DIV_ZERO_BYPASS_EN
      e.dz = 1'b1;
`endif
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    res_t e;
    if (in_valid && in_ready) begin
      exp_q.push_back(ref_div(in_a, in_b, in_tag));
      in_xfer = 1'b1;
    end
    if (out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) chk("unexpected_result", 64'd1, 64'd0);
      else begin
        e = exp_q.pop_front();
        chk("result", {27'd0, out_q, out_r, out_tag, out_dz}, {27'd0, e});
      end
    end
    if (div_start) begin
      chk("start_single_pulse", {63'd0, prev_start}, 64'd0);
      starts++;
    end
    prev_start = div_start;
    if (m_pend) chk("div_ops_stable", {32'd0, div_a, div_b}, {32'd0, m_a, m_b});
    chk("in_ready_rule", {63'd0, in_ready}, {63'd0, (level != 3'(DEPTH))});
  endtask

  // One clock: sample at the falling edge, return 1 time unit after the rising edge.
  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    if (rnd_ready) out_ready = ($urandom_range(9) < 7);
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [TAG_W-1:0] tag);
    in_valid = 1'b1; in_a = a; in_b = b; in_tag = tag; in_xfer = 1'b0;
    for (int i = 0; i < 400 && !in_xfer; i++) step();
    if (!in_xfer) chk("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int k);
    k = 0;
    while (!out_valid && k < 400) begin step(); k++; end
    if (!out_valid) chk("out_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (!(exp_q.size() == 0 && !busy && level == 0 && !out_valid) && i < 3000) begin
      step(); i++;
    end
    chk("drained", {61'd0, exp_q.size() == 0, !busy, level == 0}, 64'd7);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vt[8];
    int   k, s0, n0;
    logic [15:0] q0, r0;
    logic [TAG_W-1:0] t0;
    logic seen;

    vt[0] = '{16'd100,   16'd7,     4'd3,  16'd14,    16'd2};
    vt[1] = '{16'd65535, 16'd255,   4'd1,  16'd257,   16'd0};
    vt[2] = '{16'd1000,  16'd1,     4'd2,  16'd1000,  16'd0};
    vt[3] = '{16'd5,     16'd9,     4'd4,  16'd0,     16'd5};
    vt[4] = '{16'd65535, 16'd65535, 4'd5,  16'd1,     16'd0};
    vt[5] = '{16'd40000, 16'd3,     4'd6,  16'd13333, 16'd1};
    vt[6] = '{16'd12345, 16'd100,   4'd7,  16'd123,   16'd45};
    vt[7] = '{16'd0,     16'd5,     4'd15, 16'd0,     16'd0};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_div_start", {63'd0, div_start}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_level", {61'd0, level}, 64'd0);
    chk("rst_out_bus", {27'd0, out_q, out_r, out_tag, out_dz}, 64'd0);
    chk("rst_div_ops", {32'd0, div_a, div_b}, 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Single request: push edge, pop edge, ISSUE, lat edges in the divider, one capture edge
    out_ready = 1'b1;
    s0 = starts;
    send(16'd100, 16'd7, 4'd3);
    wait_out(k);
    chk("single_latency", 64'(k), 64'(lat + 3));
    chk("single_q", {48'd0, out_q}, 64'd14);
    chk("single_r", {48'd0, out_r}, 64'd2);
    chk("single_tag", {60'd0, out_tag}, 64'd3);
    step();
    chk("single_valid_one_cycle", {63'd0, out_valid}, 64'd0);
    chk("single_start_count", 64'(starts - s0), 64'd1);

    foreach (vt[i]) begin
      send(vt[i].a, vt[i].b, vt[i].tag);
      wait_out(k);
      chk("table_q", {48'd0, out_q}, {48'd0, vt[i].q});
      chk("table_r", {48'd0, out_r}, {48'd0, vt[i].r});
      chk("table_tag", {60'd0, out_tag}, {60'd0, vt[i].tag});
      step();
    end
    drain();

    // Burst fill behind a stalled division
    lat = 40;
    n0 = n_out;
    send(16'd7, 16'd2, 4'd0);
    repeat (3) step();
    for (int i = 1; i <= 4; i++) send(16'(1000 + i), 16'(i + 1), 4'(i));
    chk("burst_level", {61'd0, level}, 64'd4);
    chk("burst_in_ready", {63'd0, in_ready}, 64'd0);
    in_valid = 1'b1; in_a = 16'd50; in_b = 16'd6; in_tag = 4'd5; in_xfer = 1'b0;
    repeat (5) step();
    chk("burst_fifth_held", {63'd0, in_xfer}, 64'd0);
    chk("burst_level_full", {61'd0, level}, 64'd4);
    lat = 4;
    for (int i = 0; i < 400 && !in_xfer; i++) step();
    chk("burst_fifth_accepted", {63'd0, in_xfer}, 64'd1);
    in_valid = 1'b0;
    drain();
    chk("burst_result_count", 64'(n_out - n0), 64'd6);

    // Backpressure: result held while the FIFO keeps filling
    out_ready = 1'b0;
    send(16'd300, 16'd7, 4'd9);
    wait_out(k);
    q0 = out_q; r0 = out_r; t0 = out_tag; s0 = starts;
    chk("bp_q", {48'd0, q0}, 64'd42);
    chk("bp_r", {48'd0, r0}, 64'd6);
    for (int i = 0; i < 10; i++) begin
      if (i < 4) send(16'(200 + i), 16'd3, 4'(10 + i));
      else step();
      chk("bp_hold", {27'd0, out_valid, out_q, out_r, out_tag}, {27'd0, 1'b1, q0, r0, t0});
    end
    chk("bp_no_start", 64'(starts), 64'(s0));
    chk("bp_level_full", {61'd0, level}, 64'd4);
    chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
    out_ready = 1'b1;
    drain();

    // Stale done from the previous operation must be ignored
    stale = 1'b1;
    send(16'd1000, 16'd3, 4'd1);
    drain();
    send(16'd65535, 16'd255, 4'd2);
    wait_out(k);
    chk("stale_latency", 64'(k), 64'(lat + 3));
    chk("stale_q", {48'd0, out_q}, 64'd257);
    chk("stale_r", {48'd0, out_r}, 64'd0);
    chk("stale_tag", {60'd0, out_tag}, 64'd2);
    stale = 1'b0;
    drain();

    // Zero divisor
    s0 = starts;
    send(16'd1234, 16'd0, 4'd5);
    wait_out(k);
    chk("dz_q", {48'd0, out_q}, 64'hFFFF);
    chk("dz_r", {48'd0, out_r}, 64'd1234);
`ifdef DIV_ZERO_BYPASS_EN
    chk("dz_latency", 64'(k), 64'd1);
    chk("dz_flag", {63'd0, out_dz}, 64'd1);
    chk("dz_no_start", 64'(starts - s0), 64'd0);
`else
    chk("dz_latency", 64'(k), 64'(lat + 3));
    chk("dz_flag", {63'd0, out_dz}, 64'd0);
    chk("dz_issued", 64'(starts - s0), 64'd1);
`endif
    drain();

    // Reset during WAIT with two requests queued
    lat = 20;
    send(16'd500, 16'd5, 4'd6);
    repeat (3) step();
    send(16'd10, 16'd2, 4'd7);
    send(16'd20, 16'd3, 4'd8);
    chk("rw_level_before", {61'd0, level}, 64'd2);
    chk("rw_busy_before", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    #1;
    chk("rw_level", {61'd0, level}, 64'd0);
    chk("rw_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rw_busy", {63'd0, busy}, 64'd0);
    chk("rw_in_ready", {63'd0, in_ready}, 64'd1);
    exp_q.delete();
    repeat (2) step();
    reset = 1'b0;
    lat = 4;
    s0 = starts;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    chk("rw_no_stale_result", {63'd0, seen}, 64'd0);
    chk("rw_no_start", 64'(starts - s0), 64'd0);

    // Randomised traffic against the scoreboard
    rnd_ready = 1'b1;
    n0 = n_out;
    for (int i = 0; i < 150; i++) begin
      logic [15:0] a, b;
      lat = $urandom_range(6, 1);
      stale = 1'($urandom_range(1));
      a = 16'($urandom);
      case ($urandom_range(9))
        0:          b = 16'd0;
        1, 2, 3, 4: b = 16'($urandom_range(15, 1));
        default:    b = 16'($urandom);
      endcase
      send(a, b, 4'(i));
      repeat ($urandom_range(2)) step();
    end
    drain();
    chk("random_result_count", 64'(n_out - n0), 64'd150);
    rnd_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
